clk_div_mon: RTL and testbench
==============================

# clk_div_mon

Measurement stage that sits directly downstream of the team's clock dividers. It samples a divided clock (e.g. a divide-by-3, 50 %-duty output) as data in a faster reference clock domain, and measures its average period and high time over a fixed number of periods. It compares both against expected values and flags ratio, duty and stuck-clock faults. Its purpose is on-chip self-check and bench checking of divider outputs.

## Interface
Parameters:
- `CNT_W`, 8: width of the per-period counters and of the expected/measured values.
- `NUM_PER`, 4: periods per measurement. Must be a power of two, ≥1.

Ports:
- `iclk`  in  1: reference clock. Only clock in the block.
- `rst`  in  1: synchronous, active-high reset.
- `clk_in`  in  1: monitored clock, asynchronous to `iclk` and treated as data. Valid only if its frequency is ≤ `iclk`/4.
- `start`  in  1: single-cycle request to begin a measurement.
- `exp_per`  in  CNT_W: expected period in `iclk` cycles.
- `exp_high`  in  CNT_W: expected high time in `iclk` cycles.
- `tol`  in  4: allowed absolute deviation in `iclk` cycles.
- `busy`  out  1: measurement in progress.
- `done`  out  1: one-cycle pulse when results are valid.
- `per_avg`  out  CNT_W: measured average period.
- `high_avg`  out  CNT_W: measured average high time.
- `err_per`, `err_high`, `timeout`  out  1 each: fault flags. Held until the next `start`.

## Operation
- Front end: `clk_in` passes through a 2-flop synchronizer, then a registered copy for edge detection. This produces single-cycle `rise` and `fall` pulses.
- FSM states are IDLE, ARM, MEAS and DONE.
- IDLE: when `start`=1, go to ARM. On the same edge, clear the sums, clear the period index and clear all flags.
- ARM: wait for the first `rise`, then go to MEAS. Both counters load 1.
- MEAS:
  - The period counter increments every cycle. The high counter increments every cycle until `fall`, then holds.
  - On each `rise`, add the period count to `per_sum` and the high count to `high_sum`. Reload both counters to 1 and increment the period index.
  - After the `NUM_PER`-th `rise`, go to DONE.
- DONE:
  - `per_avg` = `per_sum` >> log2(`NUM_PER`), truncated. `high_avg` is derived from `high_sum` the same way.
  - `err_per` = |`per_avg` − `exp_per`| > `tol`. `err_high` is defined the same way.
  - Pulse `done` and return to IDLE.
- Sum width: CNT_W + log2(NUM_PER). The sums cannot overflow.
- Timeout: in ARM or MEAS, a counter reaching 2^CNT_W−1 with no `rise` triggers a timeout. This covers a stuck-high or stuck-low `clk_in`.
  - Set `timeout`=1, set `err_per`=1 and `err_high`=1, then go to DONE.
  - On a timeout the outputs `per_avg` and `high_avg` read all-ones.
- `start` is ignored outside IDLE.

## Timing
- Reset values:
  - All outputs are 0, and the FSM is in IDLE.
  - Internal state is cleared: counters, sums, period index and the synchronizer/edge-detect flops (the latter reset to 0).
- Edge detection adds 3 `iclk` cycles of latency. The latency is equal for `rise` and `fall`, so it cancels in the measurements.
- A clean periodic `clk_in` of period P gives a measured period of exactly P, and a high time of H gives a measured high time of exactly H.
  - Exception: sampling jitter of ±1 cycle is allowed for asynchronous sources.
- A `rise` in the same cycle that `start` is accepted is not used. Arming begins on the following cycle.
- `done` is asserted for exactly one cycle, one cycle after the final `rise` (or after the timeout cycle). Results and flags update on the same edge that `done` asserts.
- `busy`=1 from the cycle after `start` is accepted through the `done` cycle inclusive.
- `rst` mid-measurement: on the next edge, everything returns to reset values. No `done` pulse is produced.

## Structure
- The package `clk_mon_pkg` holds:
  - the FSM state enum (IDLE, ARM, MEAS, DONE);
  - the `LOG2_NUM` helper constant;
  - the counter saturation constant.
- Sub-module `sync_edge`: 2-flop synchronizer plus edge detector.
  - Inputs: `iclk`, `rst`, asynchronous input.
  - Outputs: `rise`, `fall` pulses.
- The top level contains the FSM, counters, accumulators and comparators.

## Test plan
- `clk_in` period 12, high 6; `exp_per`=12, `exp_high`=6, `tol`=0 → after 4 periods, `done` pulses; `per_avg`=12, `high_avg`=6; no flags set.
- Divide-by-3 emulation, with `iclk` 8× the source (period 24, high 12); `exp` = 24/12 → no errors. Repeat with high=8 → `err_high`=1, `err_per`=0.
- `clk_in` held at 0 after `start` → `timeout`=1 after 255 cycles; `err_per`=`err_high`=1; `per_avg`=255; `done` pulses once.
- `start` pulsed again while `busy` → ignored; results match a single measurement; exactly one `done`.
- `rst` asserted mid-MEAS → next cycle all outputs are 0 and the FSM is in IDLE; no `done`. A new `start` then measures correctly.
- `start` in the same cycle as a `rise` → that edge is skipped; measurement aligns to the next `rise`; `per_avg` is still exact.

Source files
------------

// File: rtl/clk_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor: FSM encoding,
// period-count log2 and counter saturation value.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // floor(log2(n)); NUM_PER is a power of two so this is exact
  function automatic int unsigned log2_num(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((n >> i) != 0) r = i;
    end
    return r;
  endfunction

  // all-ones value of a w-bit counter
  function automatic int unsigned cnt_sat(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus registered
// single-cycle rise/fall pulses; both pulses see identical latency.
module sync_edge (
  input  logic iclk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    meta_d = async_in;
    sync_d = meta_q;
    prev_d = sync_q;
    rise_d = sync_q & ~prev_q;
    fall_d = ~sync_q & prev_q;
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/clk_div_mon.sv
// Measures average period and high time of a divided clock over NUM_PER
// periods in the iclk domain and flags ratio, duty and stuck-clock faults.
module clk_div_mon
  import clk_mon_pkg::*;
#(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned NUM_PER = 4
) (
  input  logic             iclk,
  input  logic             rst,
  input  logic             clk_in,
  input  logic             start,
  input  logic [CNT_W-1:0] exp_per,
  input  logic [CNT_W-1:0] exp_high,
  input  logic [3:0]       tol,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] per_avg,
  output logic [CNT_W-1:0] high_avg,
  output logic             err_per,
  output logic             err_high,
  output logic             timeout
);

  localparam int unsigned     LOG2_NUM = log2_num(NUM_PER);
  localparam int unsigned     SUM_W    = CNT_W + LOG2_NUM;
  localparam int unsigned     IDX_W    = (LOG2_NUM > 0) ? LOG2_NUM : 1;
  localparam logic [CNT_W-1:0] SAT      = CNT_W'(cnt_sat(CNT_W));
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PER - 1);

  logic rise, fall;

  sync_edge u_sync_edge (
    .iclk     (iclk),
    .rst      (rst),
    .async_in (clk_in),
    .rise     (rise),
    .fall     (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic             high_run_q, high_run_d;
  logic [SUM_W-1:0] per_sum_q, per_sum_d;
  logic [SUM_W-1:0] high_sum_q, high_sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] per_avg_q, per_avg_d;
  logic [CNT_W-1:0] high_avg_q, high_avg_d;
  logic             err_per_q, err_per_d;
  logic             err_high_q, err_high_d;
  logic             timeout_q, timeout_d;

  logic [SUM_W-1:0] per_sum_nx, high_sum_nx;
  logic [CNT_W-1:0] per_avg_nx, high_avg_nx;

  function automatic logic out_of_tol(input logic [CNT_W-1:0] a,
                                      input logic [CNT_W-1:0] b,
                                      input logic [3:0]       t);
    logic [CNT_W-1:0] diff;
    diff = (a >= b) ? (a - b) : (b - a);
    return 32'(diff) > 32'(t);
  endfunction

  always_comb begin
    per_sum_nx  = per_sum_q + SUM_W'(per_cnt_q);
    high_sum_nx = high_sum_q + SUM_W'(high_cnt_q);
    per_avg_nx  = CNT_W'(per_sum_nx >> LOG2_NUM);
    high_avg_nx = CNT_W'(high_sum_nx >> LOG2_NUM);
  end

  // next-state and datapath
  always_comb begin
    state_d    = state_q;
    per_cnt_d  = per_cnt_q;
    high_cnt_d = high_cnt_q;
    high_run_d = high_run_q;
    per_sum_d  = per_sum_q;
    high_sum_d = high_sum_q;
    idx_d      = idx_q;
    per_avg_d  = per_avg_q;
    high_avg_d = high_avg_q;
    err_per_d  = err_per_q;
    err_high_d = err_high_q;
    timeout_d  = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_ARM;
          per_cnt_d  = CNT_W'(1);
          high_cnt_d = CNT_W'(1);
          high_run_d = 1'b0;
          per_sum_d  = '0;
          high_sum_d = '0;
          idx_d      = '0;
          err_per_d  = 1'b0;
          err_high_d = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      ST_ARM, ST_MEAS: begin
        if (rise) begin
          state_d    = ST_MEAS;
          per_cnt_d  = CNT_W'(1);
          high_cnt_d = CNT_W'(1);
          high_run_d = 1'b1;
          if (state_q == ST_MEAS) begin
            per_sum_d  = per_sum_nx;
            high_sum_d = high_sum_nx;
            idx_d      = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
              state_d    = ST_DONE;
              per_avg_d  = per_avg_nx;
              high_avg_d = high_avg_nx;
              err_per_d  = out_of_tol(per_avg_nx, exp_per, tol);
              err_high_d = out_of_tol(high_avg_nx, exp_high, tol);
            end
          end
        end else if (per_cnt_q == SAT) begin
          // period counter always dominates the high counter, so it alone catches a stuck input
          state_d    = ST_DONE;
          per_avg_d  = '1;
          high_avg_d = '1;
          err_per_d  = 1'b1;
          err_high_d = 1'b1;
          timeout_d  = 1'b1;
        end else begin
          per_cnt_d = per_cnt_q + CNT_W'(1);
          if (high_run_q && !fall) high_cnt_d = high_cnt_q + CNT_W'(1);
          if (fall) high_run_d = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    done_d = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge iclk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      per_cnt_q  <= '0;
      high_cnt_q <= '0;
      high_run_q <= 1'b0;
      per_sum_q  <= '0;
      high_sum_q <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      per_avg_q  <= '0;
      high_avg_q <= '0;
      err_per_q  <= 1'b0;
      err_high_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      per_cnt_q  <= per_cnt_d;
      high_cnt_q <= high_cnt_d;
      high_run_q <= high_run_d;
      per_sum_q  <= per_sum_d;
      high_sum_q <= high_sum_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      per_avg_q  <= per_avg_d;
      high_avg_q <= high_avg_d;
      err_per_q  <= err_per_d;
      err_high_q <= err_high_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign per_avg  = per_avg_q;
  assign high_avg = high_avg_q;
  assign err_per  = err_per_q;
  assign err_high = err_high_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_clk_div_mon.sv
// Directed bench for clk_div_mon: vector table of clock shapes plus
// hand-written timeout, busy-restart, reset and start/rise-alignment cases.
module tb_clk_div_mon;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned NUM_PER = 4;

  logic             iclk = 1'b0;
  logic             rst = 1'b1;
  logic             clk_in = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] exp_per = '0;
  logic [CNT_W-1:0] exp_high = '0;
  logic [3:0]       tol = '0;
  logic             busy, done, err_per, err_high, timeout;
  logic [CNT_W-1:0] per_avg, high_avg;

  int errors = 0;
  int checks = 0;

  clk_div_mon #(.CNT_W(CNT_W), .NUM_PER(NUM_PER)) dut (
    .iclk     (iclk),
    .rst      (rst),
    .clk_in   (clk_in),
    .start    (start),
    .exp_per  (exp_per),
    .exp_high (exp_high),
    .tol      (tol),
    .busy     (busy),
    .done     (done),
    .per_avg  (per_avg),
    .high_avg (high_avg),
    .err_per  (err_per),
    .err_high (err_high),
    .timeout  (timeout)
  );

  always #5 iclk = ~iclk;

  // monitored-clock source, changes 1 ns after iclk rises
  int gen_per = 12;
  int gen_high = 6;
  int gen_cnt = 0;
  bit gen_en = 1'b1;
  always @(posedge iclk) begin
    #1;
    if (gen_cnt + 1 >= gen_per) gen_cnt = 0;
    else gen_cnt = gen_cnt + 1;
    clk_in = gen_en ? (gen_cnt < gen_high) : 1'b0;
  end

  typedef struct {
    int per; int high;
    int e_per; int e_high; int tol;
    int a_per; int a_high; bit er_p; bit er_h;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge iclk); start = 1'b1;
    @(negedge iclk); start = 1'b0;
  endtask

  // lat = index of the negedge (1 = cycle after start accepted) where done is seen
  task automatic wait_done(input int budget, output int lat, output bit ok);
    lat = 1; ok = 1'b0;
    while (lat < budget) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge iclk); lat++;
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin @(negedge iclk); if (done) n++; end
  endtask

  task automatic set_src(input int per, input int high, input int ep, input int eh, input int t);
    gen_per = per; gen_high = high;
    exp_per = CNT_W'(ep); exp_high = CNT_W'(eh); tol = 4'(t);
    repeat (3 * per) @(negedge iclk);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int lat; bit ok;
    set_src(v.per, v.high, v.e_per, v.e_high, v.tol);
    pulse_start();
    wait_done((NUM_PER + 2) * v.per + 20, lat, ok);
    chk($sformatf("v%0d_done", id), 32'(ok), 1);
    chk($sformatf("v%0d_per_avg", id), 32'(per_avg), 32'(v.a_per));
    chk($sformatf("v%0d_high_avg", id), 32'(high_avg), 32'(v.a_high));
    chk($sformatf("v%0d_err_per", id), 32'(err_per), 32'(v.er_p));
    chk($sformatf("v%0d_err_high", id), 32'(err_high), 32'(v.er_h));
    chk($sformatf("v%0d_timeout", id), 32'(timeout), 0);
    chk($sformatf("v%0d_busy", id), 32'(busy), 1);
    @(negedge iclk);
    chk($sformatf("v%0d_done_1cyc", id), 32'(done), 0);
    chk($sformatf("v%0d_err_held", id), 32'(err_high), 32'(v.er_h));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n, min_lat, max_lat;
    bit ok;

    //            per high ep  eh  tol ap  ah  erp erh
    vecs[0] = '{ 12,  6, 12,  6, 0,  12,  6, 0, 0};
    vecs[1] = '{ 24, 12, 24, 12, 0,  24, 12, 0, 0};
    vecs[2] = '{ 24,  8, 24, 12, 0,  24,  8, 0, 1};
    vecs[3] = '{ 24,  8, 24, 12, 4,  24,  8, 0, 0};
    vecs[4] = '{ 24,  8, 24, 12, 3,  24,  8, 0, 1};
    vecs[5] = '{ 10,  3, 12,  3, 1,  10,  3, 1, 0};
    vecs[6] = '{200,100,190,110,15, 200,100, 0, 0};

    repeat (3) @(negedge iclk);
    rst = 1'b0;
    @(negedge iclk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_per_avg", 32'(per_avg), 0);
    chk("rst_high_avg", 32'(high_avg), 0);
    chk("rst_err_per", 32'(err_per), 0);
    chk("rst_err_high", 32'(err_high), 0);
    chk("rst_timeout", 32'(timeout), 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // stuck-low input: timeout after the counter saturates
    set_src(12, 6, 12, 6, 0);
    gen_en = 1'b0;
    repeat (12) @(negedge iclk);
    pulse_start();
    wait_done(400, lat, ok);
    chk("to_done", 32'(ok), 1);
    chk("to_latency", 32'(lat), 256);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_err_per", 32'(err_per), 1);
    chk("to_err_high", 32'(err_high), 1);
    chk("to_per_avg", 32'(per_avg), 255);
    chk("to_high_avg", 32'(high_avg), 255);
    count_dones(20, n);
    chk("to_single_done", 32'(n), 0);
    gen_en = 1'b1;

    // second start while busy is ignored
    set_src(12, 6, 12, 6, 0);
    pulse_start();
    repeat (19) @(negedge iclk);
    chk("rs_busy", 32'(busy), 1);
    start = 1'b1;
    @(negedge iclk); start = 1'b0;
    wait_done(120, lat, ok);
    lat = lat + 20;
    chk("rs_done", 32'(ok), 1);
    chk("rs_latency_ok", 32'(lat <= 61), 1);
    chk("rs_per_avg", 32'(per_avg), 12);
    chk("rs_high_avg", 32'(high_avg), 6);
    chk("rs_timeout", 32'(timeout), 0);
    count_dones(100, n);
    chk("rs_single_done", 32'(n), 0);

    // reset in the middle of a measurement
    set_src(12, 6, 12, 6, 0);
    pulse_start();
    repeat (30) @(negedge iclk);
    rst = 1'b1;
    @(negedge iclk); rst = 1'b0;
    chk("mr_busy", 32'(busy), 0);
    chk("mr_done", 32'(done), 0);
    chk("mr_per_avg", 32'(per_avg), 0);
    chk("mr_high_avg", 32'(high_avg), 0);
    chk("mr_err_per", 32'(err_per), 0);
    count_dones(100, n);
    chk("mr_no_done", 32'(n), 0);
    run_vec(vecs[0], 10);

    // sweep start over every phase of a 12-cycle period: a rise coinciding
    // with start must be skipped, giving first-rise distance 1..12
    set_src(12, 6, 12, 6, 0);
    min_lat = 1000; max_lat = 0;
    for (int k = 0; k < 12; k++) begin
      int w;
      w = 0;
      while (gen_cnt != k && w < 30) begin @(negedge iclk); w++; end
      pulse_start();
      wait_done(100, lat, ok);
      chk($sformatf("ph%0d_done", k), 32'(ok), 1);
      chk($sformatf("ph%0d_per_avg", k), 32'(per_avg), 12);
      if (lat < min_lat) min_lat = lat;
      if (lat > max_lat) max_lat = lat;
    end
    chk("ph_min_latency", 32'(min_lat), 50);
    chk("ph_max_latency", 32'(max_lat), 61);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
